// File: rtl/i2c_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : i2c_fifo_flex
// Description : Parametrised single-clock FIFO for the I2C master command and
//               data path. It sits between the register interface (writer) and
//               the I2C master engine (reader). It supports simultaneous
//               read/write, an optional first-word-fall-through read mode, a
//               level output, programmable almost-full and almost-empty flags,
//               sticky overflow and underflow flags, and a synchronous flush.
// Ports       : i2c_clock_in      - clock; all state changes on the rising edge
//               i2c_reset_n_in    - asynchronous active-low reset
//               flush_in          - synchronous clear of all FIFO state
//               wr_en_in/data_in  - write request and write data
//               rd_en_in          - read request (standard) / pop (FWFT)
//               data_out          - read data
//               data_valid_out    - data_out holds a valid word
//               fifo_full/empty   - level == DEPTH / level == 0
//               fifo_almost_full  - level >= AFULL_THRESH
//               fifo_almost_empty - level <= AEMPTY_THRESH
//               fifo_level_out    - number of stored words (0..DEPTH)
//               overflow_out      - sticky: a write was dropped
//               underflow_out     - sticky: a read hit an empty FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_fifo_flex #(
    parameter int FIFO_WIDTH    = 15,
    parameter int FIFO_ADDR     = 9,
    parameter int AFULL_THRESH  = (1 << FIFO_ADDR) - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT_MODE     = 0
) (
    input  logic                  i2c_clock_in,
    input  logic                  i2c_reset_n_in,
    input  logic                  flush_in,
    input  logic                  wr_en_in,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic [FIFO_ADDR:0]    fifo_level_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);

    localparam int                 c_DEPTH   = 1 << FIFO_ADDR;
    localparam logic [FIFO_ADDR:0] c_LVL_MAX = (FIFO_ADDR+1)'(c_DEPTH);
    localparam logic [FIFO_ADDR:0] c_AFULL   = (FIFO_ADDR+1)'(AFULL_THRESH);
    localparam logic [FIFO_ADDR:0] c_AEMPTY  = (FIFO_ADDR+1)'(AEMPTY_THRESH);
    localparam logic [FIFO_ADDR:0] c_LVL_ONE = (FIFO_ADDR+1)'(1);
    localparam logic [FIFO_ADDR-1:0] c_PTR_ONE = FIFO_ADDR'(1);

    logic [FIFO_WIDTH-1:0]  r_mem [c_DEPTH];
    logic [FIFO_ADDR-1:0]   r_wr_ptr;
    logic [FIFO_ADDR-1:0]   r_rd_ptr;
    logic [FIFO_ADDR:0]     r_level;
    logic                   r_overflow;
    logic                   r_underflow;

    logic w_rd_ok;
    logic w_wr_ok;
    logic w_do_rd;
    logic w_do_wr;

    // Status flags are pure decodes of the registered level.
    assign fifo_full         = (r_level == c_LVL_MAX);
    assign fifo_empty        = (r_level == '0);
    assign fifo_almost_full  = (r_level >= c_AFULL);
    assign fifo_almost_empty = (r_level <= c_AEMPTY);
    assign fifo_level_out    = r_level;
    assign overflow_out      = r_overflow;
    assign underflow_out     = r_underflow;

    // A write into a full FIFO is still accepted when a read frees a slot in
    // the same cycle; a read of an empty FIFO is never accepted.
    assign w_rd_ok = rd_en_in & ~fifo_empty;
    assign w_wr_ok = wr_en_in & (~fifo_full | w_rd_ok);

    // Flush suppresses both transfers.
    assign w_do_rd = w_rd_ok & ~flush_in;
    assign w_do_wr = w_wr_ok & ~flush_in;

    // Storage is deliberately left out of reset.
    always_ff @(posedge i2c_clock_in) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
        if (!i2c_reset_n_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_do_wr && !w_do_rd) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (w_do_rd && !w_do_wr) begin
                r_level <= r_level - c_LVL_ONE;
            end
            if (wr_en_in && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (rd_en_in && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT_MODE != 0) begin : g_fwft
            // Head word is presented combinationally; rd_en_in only pops.
            assign data_out       = r_mem[r_rd_ptr];
            assign data_valid_out = ~fifo_empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] r_data;
            logic                  r_valid;

            always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
                if (!i2c_reset_n_in) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else if (flush_in) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_do_rd;
                    if (w_do_rd) begin
                        r_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign data_out       = r_data;
            assign data_valid_out = r_valid;
        end
    endgenerate

endmodule
`default_nettype wire
